// File: rtl/subarashii_pkg.sv
// +------------------------------------------------------------------+
// | subarashii_pkg : opcode, sequencer state and pcSrc encodings      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

package subarashii_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_SWP = 4'h9;
  localparam logic [3:0] OP_LDW = 4'hA;
  localparam logic [3:0] OP_STW = 4'hB;
  localparam logic [3:0] OP_BRZ = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_RSV = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } seq_state_e;

  localparam logic [1:0] PCSRC_INC = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

endpackage

`default_nettype wire

// File: rtl/seq_wait_timer.sv
// +------------------------------------------------------------------+
// | seq_wait_timer : 8-bit memory wait counter with expiry flag       |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module seq_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= 8'd0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Fires on the unacked cycle that brings the count up to LIMIT.
  assign expire_o = inc_i && (cnt_q == 8'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// +------------------------------------------------------------------+
// | cpu_sequencer : multi-cycle FETCH/DECODE/EXEC/MEM/WB controller   |
// | Optional SEQ_MEM_TIMEOUT_EN : fault on memAck timeout             |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module cpu_sequencer
  import subarashii_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       branchTaken,
  input  logic       memAck,
  output logic       memReq,
  output logic       memWe,
  output logic       memAddrSel,
  output logic       irWrite,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic       regWriteEn,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  if (MEM_TIMEOUT == 0 || MEM_TIMEOUT > 255) begin : g_bad_mem_timeout
    $error("MEM_TIMEOUT must lie in 1..255");
  end

  seq_state_e state_q, state_d;
  logic       fetch_pend_q, fetch_pend_d;
  logic       w_req;
  logic       w_timeout;

  // A fetch request, once raised, stays up until acked even if run falls.
  assign w_req = !rst && (((state_q == ST_FETCH) && (run || fetch_pend_q)) ||
                          (state_q == ST_MEM));

`ifdef SEQ_MEM_TIMEOUT_EN
  logic w_clr;
  assign w_clr = (state_d != state_q);

  seq_wait_timer #(
    .LIMIT    (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (w_clr),
    .inc_i    (w_req & ~memAck),
    .expire_o (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      fetch_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pend_q <= fetch_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pend_d = 1'b0;
    memReq       = w_req;
    memWe        = 1'b0;
    memAddrSel   = 1'b0;
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    pcSrc        = PCSRC_INC;
    regWriteEn   = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (w_req) begin
          if (memAck) begin
            irWrite = 1'b1;
            pcWrite = 1'b1;
            state_d = ST_DECODE;
          end else if (w_timeout) begin
            state_d = ST_FAULT;
          end else begin
            fetch_pend_d = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        if (opcode == OP_HLT)      state_d = ST_HALT;
        else if (opcode == OP_RSV) state_d = ST_FAULT;
        else                       state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode)
          OP_LDW, OP_STW: state_d = ST_MEM;
          OP_BRZ: begin
            pcWrite = branchTaken;
            pcSrc   = PCSRC_BR;
            state_d = ST_FETCH;
          end
          OP_JAL: begin
            regWriteEn = 1'b1;
            pcWrite    = 1'b1;
            pcSrc      = PCSRC_JMP;
            state_d    = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        memAddrSel = 1'b1;
        memWe      = (opcode == OP_STW);
        if (memAck) begin
          state_d = (opcode == OP_STW) ? ST_FETCH : ST_WB;
        end else if (w_timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        regWriteEn = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default: begin
        fault   = 1'b1;
        state_d = ST_FAULT;
      end
    endcase

    if (rst) begin
      memWe      = 1'b0;
      memAddrSel = 1'b0;
      irWrite    = 1'b0;
      pcWrite    = 1'b0;
      pcSrc      = PCSRC_INC;
      regWriteEn = 1'b0;
      halted     = 1'b0;
      fault      = 1'b0;
    end
  end

  assign state = rst ? 3'(ST_FETCH) : 3'(state_q);

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// +------------------------------------------------------------------+
// | tb_cpu_sequencer : scoreboard bench for cpu_sequencer             |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module tb_cpu_sequencer;

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       branchTaken = 1'b0;
  logic       memAck = 1'b0;
  logic       memReq, memWe, memAddrSel, irWrite, pcWrite, regWriteEn, halted, fault;
  logic [1:0] pcSrc;
  logic [2:0] state;

  cpu_sequencer #(
    .MEM_TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .opcode      (opcode),
    .branchTaken (branchTaken),
    .memAck      (memAck),
    .memReq      (memReq),
    .memWe       (memWe),
    .memAddrSel  (memAddrSel),
    .irWrite     (irWrite),
    .pcWrite     (pcWrite),
    .pcSrc       (pcSrc),
    .regWriteEn  (regWriteEn),
    .halted      (halted),
    .fault       (fault),
    .state       (state)
  );

  always #5 clk = ~clk;

  // One expected cycle in which the sequencer shows a request or a strobe.
  typedef struct {
    int         cyc;
    logic       req;
    logic       we;
    logic       sel;
    logic       ir;
    logic       pcw;
    logic [1:0] src;
    logic       rwe;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];
  int   cur    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   sb_on  = 1'b0;

  wire [12:0] all_outs = {memReq, memWe, memAddrSel, irWrite, pcWrite, pcSrc,
                          regWriteEn, halted, fault, state};

  task automatic step();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", nm, cur, act, exp);
    end
  endtask

  task automatic push(input logic req, input logic we, input logic sel, input logic ir,
                      input logic pcw, input logic [1:0] src, input logic rwe,
                      input logic [2:0] st);
    exp_t e;
    e.cyc = cur; e.req = req; e.we = we; e.sel = sel; e.ir = ir;
    e.pcw = pcw; e.src = src; e.rwe = rwe; e.st = st;
    sb.push_back(e);
  endtask

  // Monitor: every cycle with a request or strobe must match the next expectation.
  always @(negedge clk) begin
    if (sb_on && !rst && (memReq || irWrite || pcWrite || regWriteEn)) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected cycle %0d: got req=%b ir=%b pcw=%b rwe=%b st=%0d, expected no activity",
                 cur, memReq, irWrite, pcWrite, regWriteEn, state);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cur || memReq !== e.req || irWrite !== e.ir || pcWrite !== e.pcw ||
            regWriteEn !== e.rwe || state !== e.st ||
            (e.req && (memWe !== e.we || memAddrSel !== e.sel)) ||
            (e.pcw && pcSrc !== e.src)) begin
          n_fail++;
          $display("FAIL sb_event: got cyc=%0d req=%b we=%b sel=%b ir=%b pcw=%b src=%b rwe=%b st=%0d, expected cyc=%0d req=%b we=%b sel=%b ir=%b pcw=%b src=%b rwe=%b st=%0d",
                   cur, memReq, memWe, memAddrSel, irWrite, pcWrite, pcSrc, regWriteEn, state,
                   e.cyc, e.req, e.we, e.sel, e.ir, e.pcw, e.src, e.rwe, e.st);
        end
      end
    end
  end

  // Reference model: an instruction is a list of phases whose lengths follow
  // from the opcode class and the memory wait counts chosen for it.
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                           input logic bt, input int idle);
    for (int i = 0; i < idle; i++) begin
      step(); run = 1'b0; memAck = 1'($urandom);
    end
    for (int k = 0; k <= fw; k++) begin
      step();
      run    = (k == 0) ? 1'b1 : 1'($urandom);
      memAck = (k == fw);
      push(1'b1, 1'b0, 1'b0, k == fw, k == fw, 2'b00, 1'b0, 3'd0);
    end
    step(); opcode = op; run = 1'($urandom); memAck = 1'($urandom); branchTaken = 1'($urandom);
    step(); branchTaken = bt; memAck = 1'($urandom);
    if (op == 4'hC && bt) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 3'd2);
    if (op == 4'hD)       push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 3'd2);
    if (op == 4'hA || op == 4'hB) begin
      for (int k = 0; k <= mw; k++) begin
        step(); memAck = (k == mw); branchTaken = 1'($urandom);
        push(1'b1, op == 4'hB, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 3'd3);
      end
    end
    if (op <= 4'h9 || op == 4'hA) begin
      step(); memAck = 1'($urandom);
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd4);
    end
  endtask

  task automatic do_reset();
    step(); rst = 1'b1; run = 1'b1; memAck = 1'b1;
    #1; chk("reset_forces_zero", 16'(all_outs), 16'h0);
    step(); rst = 1'b0; run = 1'b0; memAck = 1'($urandom);
    #1; chk("after_reset", 16'(all_outs), 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      step(); run = 1'b1; memAck = 1'b1; opcode = 4'($urandom);
      #1; chk("during_reset", 16'(all_outs), 16'h0);
    end
    step(); rst = 1'b0; run = 1'b0; memAck = 1'b1;
    #1; chk("reset_state", 16'(all_outs), 16'h0);

    sb_on = 1'b1;
    run_instr(4'h0, 0, 0, 1'b0, 0);   // ADD, zero-wait
    run_instr(4'hA, 2, 2, 1'b0, 0);   // LDW, two waits in FETCH and MEM
    run_instr(4'hC, 0, 0, 1'b1, 0);   // BRZ taken
    run_instr(4'hC, 1, 0, 1'b0, 2);   // BRZ not taken
    run_instr(4'hD, 0, 0, 1'b0, 0);   // JAL
    run_instr(4'hB, 0, 1, 1'b0, 1);   // STW
    run_instr(4'h9, 3, 0, 1'b1, 0);   // SWP
    for (int i = 0; i < 80; i++) begin
      run_instr(4'($urandom_range(0, 13)), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    // HLT: sticky, no requests
    step(); run = 1'b1; memAck = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 3'd0);
    step(); opcode = 4'hF; memAck = 1'($urandom);
    for (int i = 0; i < 20; i++) begin
      step(); run = 1'b1; memAck = 1'($urandom);
      #1; chk("halt_sticky", {13'h0, halted, memReq, fault}, 16'h4);
      if (i == 0) chk("halt_state", 16'(state), 16'd5);
    end
    do_reset();

    // Reserved opcode: sticky fault
    step(); run = 1'b1; memAck = 1'b1;
    push(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 3'd0);
    step(); opcode = 4'hE; run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); run = 1'b1; memAck = 1'($urandom);
      #1; chk("fault_sticky", {10'h0, fault, memReq, halted, state}, {10'h0, 3'b100, 3'd6});
    end
    do_reset();
    chk("sb_drained", 16'(sb.size()), 16'd0);
    sb_on = 1'b0;

    // Request held after run falls; reset abandons it at once
    step(); run = 1'b1; memAck = 1'b0; #1; chk("fetch_req", 16'(memReq), 16'd1);
    step(); run = 1'b0; #1; chk("fetch_req_held", 16'(memReq), 16'd1);
    step(); rst = 1'b1; #1; chk("reset_drops_req", 16'(memReq), 16'd0);
    step(); rst = 1'b0; memAck = 1'b1; #1; chk("ack_ignored_idle", 16'(all_outs), 16'h0);
    step(); memAck = 1'b0; #1; chk("still_fetch", 16'(all_outs), 16'h0);

`ifdef SEQ_MEM_TIMEOUT_EN
    // Ack on the expiring cycle wins
    for (int k = 0; k < int'(TB_TIMEOUT); k++) begin
      step(); run = (k == 0); memAck = (k == int'(TB_TIMEOUT) - 1);
    end
    #1; chk("late_ack_wins", {14'h0, irWrite, fault}, 16'h2);
    step(); memAck = 1'b0; #1; chk("late_ack_decode", {12'h0, fault, state}, 16'h1);
    do_reset();
    for (int k = 0; k < int'(TB_TIMEOUT); k++) begin
      step(); run = (k == 0); memAck = 1'b0;
      #1; chk("timeout_req_cycle", {14'h0, fault, memReq}, 16'h1);
    end
    for (int i = 0; i < 3; i++) begin
      step(); run = 1'b1; memAck = 1'b0;
      #1; chk("timeout_fault", {11'h0, fault, memReq, state}, {11'h0, 2'b10, 3'd6});
    end
`else
    for (int k = 0; k < 30; k++) begin
      step(); run = (k == 0) ? 1'b1 : 1'($urandom); memAck = 1'b0;
    end
    #1; chk("wait_forever", {11'h0, fault, memReq, state}, {11'h0, 2'b01, 3'd0});
    step(); memAck = 1'b1; #1; chk("long_wait_ack", 16'(irWrite), 16'd1);
`endif
    do_reset();

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle sequencer for the Subarashii CPU datapath. It steps each instruction through fetch, decode, execute, memory and writeback. It issues memory requests over a req/ack handshake and pulses the IR, PC and register-file write enables. It sits beside the combinational opcode decoder: the decoder supplies the datapath mux selects, and this block decides when each state element commits.

## Interface
- MEM_TIMEOUT, 16: maximum wait cycles for `memAck` before a fault (used only with SEQ_MEM_TIMEOUT_EN); range 1–255
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  permit new instruction fetch
- opcode  in  4  instruction opcode from IR, stable from DECODE until the next `irWrite`
- branchTaken  in  1  ALU zero result for BRZ, valid in EXEC
- memAck  in  1  memory completes current request this cycle
- memReq  out  1  memory request, held until acked
- memWe  out  1  request is a write (STW)
- memAddrSel  out  1  0 = PC, 1 = ALU result
- irWrite  out  1  load instruction register
- pcWrite  out  1  load PC
- pcSrc  out  2  00 = PC+1, 01 = branch target, 10 = jump target
- regWriteEn  out  1  register-file write strobe
- halted  out  1  in HALT
- fault  out  1  in FAULT
- state  out  3  current state (debug)

## Operation
- States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5, FAULT = 6. Code 7 is unreachable and decodes as FAULT.
- Strobes are decoded from the registered state plus `memAck`, `branchTaken` and `opcode`. All strobes are forced to 0 while `rst` = 1.
- FETCH
  - With `run` = 0 and no request outstanding, stay in FETCH with `memReq` = 0.
  - Otherwise drive `memReq` = 1, `memAddrSel` = 0, `memWe` = 0.
  - Once `memReq` is raised, hold it until `memAck`, even if `run` falls.
  - On `memAck`: `irWrite` = 1, `pcWrite` = 1, `pcSrc` = 00, go to DECODE.
- DECODE: one cycle.
  - Opcode 1111 (HLT): go to HALT.
  - Opcode 1110 (reserved): go to FAULT.
  - Otherwise go to EXEC.
- EXEC: one cycle, next state by opcode.
  - 0000–1001: go to WB.
  - 1010 (LDW) or 1011 (STW): go to MEM.
  - 1100 (BRZ): if `branchTaken`, pulse `pcWrite` with `pcSrc` = 01. Go to FETCH.
  - 1101 (JAL): `regWriteEn` = 1 and `pcWrite` = 1 with `pcSrc` = 10 on the same edge (link captures the already-incremented PC). Go to FETCH.
- MEM
  - Drive `memReq` = 1, `memAddrSel` = 1, and `memWe` = 1 for STW, until `memAck`.
  - On ack: STW goes to FETCH, LDW goes to WB.
- WB: `regWriteEn` = 1 for one cycle, go to FETCH.
- HALT and FAULT are sticky.
  - `halted` or `fault` = 1 respectively; all strobes 0.
  - Exit only via `rst`.

## Timing
- Reset values: state FETCH; all outputs 0; `state` = 000.
- Reset mid-request drops `memReq` in the same cycle. Memory must tolerate an abandoned request.
- `memAck` is valid in the first request cycle (zero-wait memory).
- Zero-wait latency per instruction, in cycles:
  - ALU ops and SWP: 4
  - LDW: 5
  - STW: 4
  - BRZ and JAL: 3
- Each wait cycle adds 1.
- `memAck` while `memReq` = 0 is ignored.

## Configuration
- SEQ_MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to FETCH or MEM.
  - It increments each cycle `memReq` = 1 and `memAck` = 0.
  - When it reaches MEM_TIMEOUT without an ack, the next state is FAULT and `memReq` drops.
  - An ack in that same cycle wins.
- SEQ_MEM_TIMEOUT_EN undefined:
  - The sequencer waits indefinitely.
  - FAULT is reachable only via opcode 1110.

## Structure
- Shared package `subarashii_pkg` holds:
  - opcode constants OP_ADD … OP_HLT
  - state encodings ST_FETCH … ST_FAULT
  - pcSrc encodings PCSRC_INC, PCSRC_BR, PCSRC_JMP
- Sub-module `seq_wait_timer` is the timeout counter, instantiated only under SEQ_MEM_TIMEOUT_EN.

## Test plan
- ADD (0000) with `memAck` tied 1:
  - `irWrite` and `pcWrite` in cycle 0
  - `regWriteEn` in cycle 3
  - back to FETCH in cycle 4
- LDW (1010) with `memAck` delayed 2 cycles in both FETCH and MEM:
  - `memAddrSel` = 0 then 1
  - `regWriteEn` in cycle 8
- BRZ (1100):
  - with `branchTaken` = 1: `pcWrite` and `pcSrc` = 01 in EXEC
  - with `branchTaken` = 0: no second `pcWrite`
- JAL (1101): `regWriteEn`, `pcWrite` and `pcSrc` = 10 coincide in EXEC.
- Opcode 1111:
  - `halted` = 1 and stays high
  - no `memReq` for 20 cycles
  - `rst` returns state to 000
- SEQ_MEM_TIMEOUT_EN with MEM_TIMEOUT = 4 and `memAck` held 0 in FETCH:
  - `fault` = 1 after 4 request cycles
  - `memReq` = 0 thereafter
